// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, requests to send, then shifts start/data/parity/stop out
// on device-generated clock falls and checks the device ACK. tx_busy lets the
// receive path ignore the bus while the host owns it.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES       = 1200,
   parameter int START_TIMEOUT_CYCLES = 150000,
   parameter int XFER_TIMEOUT_CYCLES  = 20000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done_strb,
   output logic       tx_error_strb,
   output logic [1:0] tx_error_code,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int TO_MAX  = (START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ?
                            START_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
   localparam int T_MAX   = (TO_MAX > INHIBIT_CYCLES) ? TO_MAX : INHIBIT_CYCLES;
   localparam int TIMER_W = $clog2(T_MAX + 1);

   localparam logic [TIMER_W-1:0] INH_LAST   = TIMER_W'(INHIBIT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] XFER_LAST  = TIMER_W'(XFER_TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMER_SAT  = '1;

   localparam logic [1:0] ERR_START = 2'b01;
   localparam logic [1:0] ERR_XFER  = 2'b10;
   localparam logic [1:0] ERR_NOACK = 2'b11;

   typedef enum logic [2:0] {
      IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE
   } state_t;

   state_t               state, state_nxt;
   logic [TIMER_W-1:0]   timer, timer_nxt, timer_inc;
   logic [3:0]           bitcnt, bitcnt_nxt;
   logic                 clk_oe_q, clk_oe_nxt;
   logic                 data_oe_q, data_oe_nxt;
   logic                 done_q, done_nxt;
   logic                 err_q, err_nxt;
   logic [1:0]           code_q, code_nxt;
   logic                 ready_q, ready_nxt;
   logic                 busy_q;
   logic                 load;
   logic                 abort;
   logic [1:0]           abort_code;

   logic                 clk_s_p0, clk_s_p1, clk_s_p2;
   logic                 data_s_p0, data_s_p1;
   logic                 fall;
   logic                 timeout_start, timeout_xfer;

   logic [7:0]           shreg;
   logic                 parity;

   // Two-flop synchronisers on both pins plus a clock history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s_p0  <= 1'b1;
         clk_s_p1  <= 1'b1;
         clk_s_p2  <= 1'b1;
         data_s_p0 <= 1'b1;
         data_s_p1 <= 1'b1;
      end else begin
         clk_s_p0  <= ps2_clk;
         clk_s_p1  <= clk_s_p0;
         clk_s_p2  <= clk_s_p1;
         data_s_p0 <= ps2_data;
         data_s_p1 <= data_s_p0;
      end
   end

   assign fall          = clk_s_p2 & ~clk_s_p1;
   assign timer_inc     = (timer == TIMER_SAT) ? timer : timer + 1'b1;
   assign timeout_start = (timer >= START_LAST);
   assign timeout_xfer  = (timer >= XFER_LAST);

   // Command byte and its odd parity, captured on accept
   always_ff @(posedge clk) begin
      if (load) begin
         shreg  <= tx_data;
         parity <= ~^tx_data;
      end
   end

   // Next-state, counters and registered-output values
   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      bitcnt_nxt  = bitcnt;
      clk_oe_nxt  = clk_oe_q;
      data_oe_nxt = data_oe_q;
      done_nxt    = 1'b0;
      err_nxt     = 1'b0;
      code_nxt    = code_q;
      load        = 1'b0;
      abort       = 1'b0;
      abort_code  = 2'b00;

      case (state)
         IDLE: begin
            if (tx_valid && ready_q) begin
               load        = 1'b1;
               state_nxt   = INHIBIT;
               timer_nxt   = '0;
               bitcnt_nxt  = 4'd0;
               clk_oe_nxt  = 1'b1;
               data_oe_nxt = (INHIBIT_CYCLES <= 1);
            end
         end

         INHIBIT: begin
            timer_nxt = timer_inc;
            if (timer >= INH_LAST) begin
               state_nxt   = REQ;
               timer_nxt   = '0;
               clk_oe_nxt  = 1'b0;
               data_oe_nxt = 1'b1;
            end else if (timer_inc >= INH_LAST) begin
               // start bit goes onto the line during the last inhibit cycle
               data_oe_nxt = 1'b1;
            end
         end

         REQ: begin
            timer_nxt = timer_inc;
            if (fall) begin
               state_nxt = DATA;
               timer_nxt = '0;
            end else if (timeout_start) begin
               abort      = 1'b1;
               abort_code = ERR_START;
            end
         end

         DATA: begin
            timer_nxt = timer_inc;
            if (fall) begin
               bitcnt_nxt = bitcnt + 4'd1;
               if (bitcnt < 4'd8) begin
                  data_oe_nxt = ~shreg[bitcnt[2:0]];
               end else if (bitcnt == 4'd8) begin
                  data_oe_nxt = ~parity;
               end else begin
                  data_oe_nxt = 1'b0;
                  state_nxt   = ACK;
               end
            end else if (timeout_xfer) begin
               abort      = 1'b1;
               abort_code = ERR_XFER;
            end
         end

         ACK: begin
            timer_nxt = timer_inc;
            if (fall) begin
               if (!data_s_p1) begin
                  state_nxt = WAIT_IDLE;
               end else begin
                  abort      = 1'b1;
                  abort_code = ERR_NOACK;
               end
            end else if (timeout_xfer) begin
               abort      = 1'b1;
               abort_code = ERR_XFER;
            end
         end

         WAIT_IDLE: begin
            timer_nxt = timer_inc;
            if (clk_s_p1 && data_s_p1) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else if (!fall && timeout_xfer) begin
               abort      = 1'b1;
               abort_code = ERR_XFER;
            end
         end

         default: begin
            state_nxt   = IDLE;
            clk_oe_nxt  = 1'b0;
            data_oe_nxt = 1'b0;
         end
      endcase

      if (abort) begin
         state_nxt   = IDLE;
         clk_oe_nxt  = 1'b0;
         data_oe_nxt = 1'b0;
         err_nxt     = 1'b1;
         code_nxt    = abort_code;
      end

      // ready only once IDLE has been held for a full cycle, so a request
      // coinciding with a done/error strobe is not taken
      ready_nxt = (state == IDLE) && (state_nxt == IDLE);
   end

   // Control state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         bitcnt    <= 4'd0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= 2'b00;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         bitcnt    <= bitcnt_nxt;
         clk_oe_q  <= clk_oe_nxt;
         data_oe_q <= data_oe_nxt;
         done_q    <= done_nxt;
         err_q     <= err_nxt;
         code_q    <= code_nxt;
         ready_q   <= ready_nxt;
         busy_q    <= ~ready_nxt;
      end
   end

   assign tx_ready      = ready_q;
   assign tx_busy       = busy_q;
   assign tx_done_strb  = done_q;
   assign tx_error_strb = err_q;
   assign tx_error_code = code_q;
   assign ps2_clk_oe    = clk_oe_q;
   assign ps2_data_oe   = data_oe_q;

endmodule
